pic_cycle_sequencer: RTL and testbench
======================================

Name: pic_cycle_sequencer

Overview:
- Instruction-cycle controller for the PIC10F200-compatible core.
- Generates the four-phase Q1..Q4 timing and holds the instruction register (IR).
- Decodes the current instruction into datapath strobes, including the ALU input mux select (literal bus vs RAM bus), ALU operation, W/RAM write enables, PC and stack control.
- Inserts flush cycles for branches and taken skips, and halts on SLEEP.

Parameters:
IR_RESET, 12'h000, IR value loaded at reset (NOP encoding).

Ports:
clk  in  1  system clock; one Q phase per clock.
rst_n  in  1  asynchronous active-low reset.
instr  in  12  program-memory word fetched at the current PC.
skip_cond  in  1  ALU skip condition (result zero for DECFSZ/INCFSZ; tested bit clear/set for BTFSC/BTFSS); valid at Q4.
ir  out  12  current instruction; literal/file fields feed the datapath.
q_phase  out  2  current phase: 0=Q1, 1=Q2, 2=Q3, 3=Q4.
alu_mux_sel  out  1  1 = ALU operand from literal/IR bus, 0 = from RAM bus.
alu_op  out  5  ALU operation code.
w_we  out  1  W register write strobe.
ram_we  out  1  file register write strobe.
pc_inc  out  1  PC increment strobe.
pc_load  out  1  PC load strobe (GOTO/CALL/RETLW).
stack_push  out  1  return stack push.
stack_pop  out  1  return stack pop.
flush  out  1  current cycle is a discarded (NOP-executed) slot.
halted  out  1  core stopped by SLEEP.

Behaviour:
- Reset (async, immediate): q_phase=0, ir=IR_RESET, flush=1, halted=0; every strobe output 0.
  - First instruction cycle after reset is therefore a fetch-only cycle.
- q_phase increments every clk and wraps 3->0. An instruction cycle is 4 clocks.
- IR capture: ir <= instr on the clk edge that ends Q4.
  - flush for the next cycle is set on that same edge when the current cycle is non-flushed and is either:
    - GOTO, CALL or RETLW; or
    - DECFSZ, INCFSZ, BTFSC or BTFSS with skip_cond=1 sampled in Q4.
  - Otherwise flush is cleared on that edge.
- alu_mux_sel and alu_op are combinational from ir and valid for the whole cycle.
- Strobe timing:
  - pc_inc = 1 in Q1 of every cycle, including flush cycles; 0 while halted.
  - w_we, ram_we, pc_load, stack_push and stack_pop assert only in Q4.
  - All strobes are forced to 0 when flush=1 or halted=1.
- Decode (d = ir[5]):
  - 0000_0000_0000 NOP, plus OPTION, CLRWDT and TRIS: no writes.
  - 0000_0000_0011 SLEEP: halted <= 1 at the end of Q4.
  - MOVWF (0000_001x_xxxx): ram_we, alu_mux_sel=0, alu_op=5'h00.
  - Byte ops (ir[11:10]=00, excluding the above):
    - alu_op={1'b0,ir[9:6]}, alu_mux_sel=0.
    - d=1 -> ram_we; d=0 -> w_we.
  - Bit ops (ir[11:10]=01):
    - alu_op={3'b100,ir[9:8]}, alu_mux_sel=0.
    - BCF/BSF -> ram_we; BTFSC/BTFSS -> no write.
  - Literal/control ops:
    - MOVLW (1100): alu_op=5'h14, w_we.
    - IORLW (1101): alu_op=5'h15, w_we.
    - ANDLW (1110): alu_op=5'h16, w_we.
    - XORLW (1111): alu_op=5'h17, w_we.
    - RETLW (1000): alu_op=5'h14, w_we, pc_load, stack_pop.
    - CALL (1001): pc_load, stack_push.
    - GOTO (101x): pc_load.
    - All of these drive alu_mux_sel=1.
- skip_cond is ignored for every non-skip instruction.
- Halt:
  - Once halted=1, q_phase keeps counting, ir holds, and all strobes stay 0 until rst_n is asserted.
  - SLEEP decoded in a flush cycle is ignored.
- Reset asserted mid-cycle (any Q phase) aborts the cycle; no partial Q4 strobe may appear.

Test Plan:
1. rst_n low during Q2 of an ADDWF cycle -> all strobes 0 and q_phase=0 in the same clock. After release: cycle 0 has flush=1 and pc_inc=1 in Q1 only; instr captured at end of Q4.
2. ir=12'h1F0 (ADDWF 0x10,f) -> alu_mux_sel=0, alu_op=5'h07, ram_we=1 in Q4 only, w_we=0. ir=12'h1D0 (d=0) -> w_we=1 in Q4, ram_we=0.
3. ir=12'hC5A (MOVLW 0x5A) -> alu_mux_sel=1, alu_op=5'h14, w_we=1 in Q4. ir=12'h800 (RETLW) -> w_we, pc_load and stack_pop all in Q4.
4. ir=12'hA05 (GOTO 5) -> pc_load=1 in Q4. Next cycle has flush=1: only pc_inc toggles, no writes. The following cycle executes normally.
5. ir=12'h2F0 (DECFSZ 0x10,f) with skip_cond=1 -> ram_we in Q4, next cycle flushed. With skip_cond=0 -> no flush. ADDWF with skip_cond=1 -> no flush.
6. ir=12'h003 (SLEEP) -> halted=1 after Q4; 20 further cycles show zero strobes. SLEEP in a flush slot -> halted stays 0.

Source files
------------

// File: rtl/pic_cycle_sequencer.sv
// pic_cycle_sequencer: four-phase Q1..Q4 instruction-cycle controller for a
// PIC10F200-class core. Holds IR, decodes datapath strobes, inserts flush
// slots after branches / taken skips and stops the core on SLEEP.
module pic_cycle_sequencer #(
  parameter logic [11:0] IR_RESET = 12'h000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] instr,
  input  logic        skip_cond,
  output logic [11:0] ir,
  output logic [1:0]  q_phase,
  output logic        alu_mux_sel,
  output logic [4:0]  alu_op,
  output logic        w_we,
  output logic        ram_we,
  output logic        pc_inc,
  output logic        pc_load,
  output logic        stack_push,
  output logic        stack_pop,
  output logic        flush,
  output logic        halted
);

  typedef enum logic [1:0] {Q1 = 2'd0, Q2 = 2'd1, Q3 = 2'd2, Q4 = 2'd3} phase_e;

  // Q4-only write/control strobes, decoded as a group
  typedef struct packed {
    logic w_we;
    logic ram_we;
    logic pc_load;
    logic stack_push;
    logic stack_pop;
  } wr_strb_t;

  phase_e     phase;
  wr_strb_t   dec_strb;
  wr_strb_t   q4_strb;
  logic       is_sleep;
  logic       is_skip;
  logic       is_branch;
  logic       mux_d;
  logic [4:0] op_d;

  // Instruction decode from the held IR; valid for the whole cycle
  always_comb begin
    op_d      = 5'h00;
    mux_d     = 1'b0;
    dec_strb  = '0;
    is_sleep  = 1'b0;
    is_skip   = 1'b0;
    is_branch = 1'b0;
    case (ir[11:10])
      2'b00: begin
        if (ir[11:5] == 7'b0000000) begin
          // NOP / OPTION / SLEEP / CLRWDT / TRIS: no datapath writes
          is_sleep = (ir[4:0] == 5'b00011);
        end else if (ir[11:5] == 7'b0000001) begin
          dec_strb.ram_we = 1'b1;              // MOVWF
        end else begin
          op_d = {1'b0, ir[9:6]};
          if (ir[5]) dec_strb.ram_we = 1'b1;
          else       dec_strb.w_we   = 1'b1;
          // DECFSZ (1011) and INCFSZ (1111)
          is_skip = (ir[9:6] == 4'b1011) || (ir[9:6] == 4'b1111);
        end
      end
      2'b01: begin
        op_d            = {3'b100, ir[9:8]};
        dec_strb.ram_we = ~ir[9];              // BCF/BSF write, BTFSx test
        is_skip         = ir[9];
      end
      2'b10: begin
        mux_d            = 1'b1;
        is_branch        = 1'b1;
        dec_strb.pc_load = 1'b1;
        case (ir[9:8])
          2'b00: begin                         // RETLW
            op_d               = 5'h14;
            dec_strb.w_we      = 1'b1;
            dec_strb.stack_pop = 1'b1;
          end
          2'b01:   dec_strb.stack_push = 1'b1; // CALL
          default: ;                           // GOTO
        endcase
      end
      default: begin                           // MOVLW/IORLW/ANDLW/XORLW
        mux_d         = 1'b1;
        op_d          = {3'b101, ir[9:8]};
        dec_strb.w_we = 1'b1;
      end
    endcase
  end

  // Phase counter, IR capture, flush/halt tracking and registered Q4 strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase   <= Q1;
      ir      <= IR_RESET;
      flush   <= 1'b1;
      halted  <= 1'b0;
      q4_strb <= '0;
    end else begin
      phase   <= phase_e'(phase + 2'd1);
      // strobes live only in Q4; loaded on the edge entering it
      q4_strb <= '0;
      if (phase == Q3 && !flush && !halted) q4_strb <= dec_strb;
      if (phase == Q4 && !halted) begin
        ir    <= instr;
        flush <= !flush && (is_branch || (is_skip && skip_cond));
        if (!flush && is_sleep) halted <= 1'b1;
      end
    end
  end

  // pc_inc also runs in flush slots; gated by rst_n so reset forces it low at once
  assign pc_inc      = rst_n && (phase == Q1) && !halted;
  assign q_phase     = phase;
  assign alu_mux_sel = mux_d;
  assign alu_op      = op_d;
  assign w_we        = q4_strb.w_we;
  assign ram_we      = q4_strb.ram_we;
  assign pc_load     = q4_strb.pc_load;
  assign stack_push  = q4_strb.stack_push;
  assign stack_pop   = q4_strb.stack_pop;

endmodule

// File: tb/tb_pic_cycle_sequencer.sv
// Bench for pic_cycle_sequencer: decode vector table, hand-written reset /
// branch / sleep sequences and random instruction streams checked against an
// instruction-level reference model.
module tb_pic_cycle_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] instr = 12'h000;
  logic        skip_cond = 1'b0;
  logic [11:0] ir;
  logic [1:0]  q_phase;
  logic        alu_mux_sel;
  logic [4:0]  alu_op;
  logic        w_we, ram_we, pc_inc, pc_load, stack_push, stack_pop, flush, halted;

  int errors = 0;
  int checks = 0;

  pic_cycle_sequencer #(.IR_RESET(12'h000)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .skip_cond(skip_cond),
    .ir(ir), .q_phase(q_phase), .alu_mux_sel(alu_mux_sel), .alu_op(alu_op),
    .w_we(w_we), .ram_we(ram_we), .pc_inc(pc_inc), .pc_load(pc_load),
    .stack_push(stack_push), .stack_pop(stack_pop), .flush(flush), .halted(halted)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Output word: ir[27:16] q_phase[15:14] mux[13] op[12:8] w[7] ram[6]
  //              pc_inc[5] pc_load[4] push[3] pop[2] flush[1] halted[0]
  function automatic logic [27:0] bundle();
    return {ir, q_phase, alu_mux_sel, alu_op, w_we, ram_we, pc_inc,
            pc_load, stack_push, stack_pop, flush, halted};
  endfunction

  task automatic chk(input string name, input logic [27:0] act, input logic [27:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model (one step per instruction) ------------
  typedef struct packed {
    logic       mux;
    logic [4:0] op;
    logic       w, ram, pcl, push, pop;
    logic       branch, skip, sleep;
  } exp_t;

  logic [11:0] m_ir;
  logic        m_flush, m_halted;

  function automatic exp_t ref_decode(input logic [11:0] i);
    exp_t e = '0;
    casez (i)
      12'b0000_0000_0011: e.sleep = 1'b1;
      12'b0000_000?_????: ;                                  // NOP group
      12'b0000_001?_????: e.ram = 1'b1;                      // MOVWF
      12'b00??_????_????: begin                              // byte ops
        e.op   = 5'(i[9:6]);
        e.ram  = i[5];
        e.w    = !i[5];
        e.skip = (i[9:6] == 4'd11) || (i[9:6] == 4'd15);     // DECFSZ, INCFSZ
      end
      12'b010?_????_????: begin e.op = 5'd16 + 5'(i[9:8]); e.ram = 1'b1; end  // BCF/BSF
      12'b011?_????_????: begin e.op = 5'd16 + 5'(i[9:8]); e.skip = 1'b1; end // BTFSC/BTFSS
      12'b1000_????_????: begin e.mux = 1; e.op = 5'h14; e.w = 1; e.pcl = 1; e.pop = 1; e.branch = 1; end
      12'b1001_????_????: begin e.mux = 1; e.pcl = 1; e.push = 1; e.branch = 1; end
      12'b101?_????_????: begin e.mux = 1; e.pcl = 1; e.branch = 1; end
      default:            begin e.mux = 1; e.op = 5'h14 + 5'(i[9:8]); e.w = 1; end  // literal ops
    endcase
    return e;
  endfunction

  function automatic logic [27:0] model_out(input int p);
    exp_t e  = ref_decode(m_ir);
    logic q4 = (p == 3) && !m_flush && !m_halted;
    return {m_ir, 2'(p), e.mux, e.op, q4 & e.w, q4 & e.ram, (p == 0) && !m_halted,
            q4 & e.pcl, q4 & e.push, q4 & e.pop, m_flush, m_halted};
  endfunction

  task automatic model_reset();
    m_ir = 12'h000; m_flush = 1'b1; m_halted = 1'b0;
  endtask

  task automatic model_end(input logic [11:0] nxt, input logic skip);
    exp_t e;
    logic taken;
    if (!m_halted) begin
      e     = ref_decode(m_ir);
      taken = !m_flush && (e.branch || (e.skip && skip));
      if (!m_flush && e.sleep) m_halted = 1'b1;
      m_flush = taken;
      m_ir    = nxt;
    end
  endtask

  // ---------------- drivers ------------------------------------------------
  logic [27:0] snap [4];

  // Runs one instruction cycle starting just after its Q1 edge; every phase
  // is compared against the model at the falling edge.
  task automatic do_cycle(input logic [11:0] nxt, input logic skip, input string tag);
    instr = nxt; skip_cond = skip;
    for (int p = 0; p < 4; p++) begin
      @(negedge clk);
      snap[p] = bundle();
      chk($sformatf("%s_q%0d", tag, p + 1), snap[p], model_out(p));
      @(posedge clk);
    end
    #1;
    model_end(nxt, skip);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0; instr = 12'h000; skip_cond = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk({tag, "_reset_state"}, bundle(), 28'h0000002);
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct packed {
    logic [11:0] ir;
    logic        skip, mux;
    logic [4:0]  op;
    logic        w, ram, pcl, push, pop, fln;
  } vec_t;

  vec_t vecs [19];

  initial begin
    logic [11:0] r;
    vecs = '{
      // ir       skip  mux   op     w     ram   pcl   push  pop   flush_next
      '{12'h1F0, 1'b1, 1'b0, 5'h07, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0},  // ADDWF f, skip ignored
      '{12'h1D0, 1'b0, 1'b0, 5'h07, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},  // ADDWF w
      '{12'hC5A, 1'b0, 1'b1, 5'h14, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},  // MOVLW
      '{12'hD01, 1'b0, 1'b1, 5'h15, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},  // IORLW
      '{12'hE0F, 1'b0, 1'b1, 5'h16, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},  // ANDLW
      '{12'hF33, 1'b1, 1'b1, 5'h17, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},  // XORLW
      '{12'h800, 1'b0, 1'b1, 5'h14, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1},  // RETLW
      '{12'hA05, 1'b0, 1'b1, 5'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1},  // GOTO
      '{12'h900, 1'b0, 1'b1, 5'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1},  // CALL
      '{12'h2F0, 1'b1, 1'b0, 5'h0B, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1},  // DECFSZ taken
      '{12'h2F0, 1'b0, 1'b0, 5'h0B, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0},  // DECFSZ not taken
      '{12'h3D0, 1'b1, 1'b0, 5'h0F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1},  // INCFSZ w taken
      '{12'h610, 1'b1, 1'b0, 5'h12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1},  // BTFSC taken
      '{12'h710, 1'b0, 1'b0, 5'h13, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},  // BTFSS not taken
      '{12'h430, 1'b1, 1'b0, 5'h10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0},  // BCF, skip ignored
      '{12'h530, 1'b0, 1'b0, 5'h11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0},  // BSF
      '{12'h021, 1'b0, 1'b0, 5'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0},  // MOVWF
      '{12'h040, 1'b1, 1'b0, 5'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},  // CLRW, skip ignored
      '{12'h002, 1'b0, 1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}   // OPTION
    };

    model_reset();
    do_reset("init");

    // Mid-cycle reset during Q2 of an ADDWF, then the fetch-only cycle 0
    do_cycle(12'h000, 1'b0, "t1_c0");
    do_cycle(12'h1F0, 1'b0, "t1_load");
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("t1_midcycle_reset", bundle(), 28'h0000002);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    do_cycle(12'h1D0, 1'b0, "t1_after");
    chk("t1_c0_flush", 28'(snap[0][1]), 28'h1);
    chk("t1_c0_pcinc_q1", 28'(snap[0][5]), 28'h1);
    chk("t1_c0_pcinc_q2", 28'(snap[1][5]), 28'h0);
    chk("t1_c0_no_q4_strobes", 28'(snap[3][7:2]), 28'h0);
    do_cycle(12'h000, 1'b0, "t1_next");
    chk("t1_ir_capture", 28'(snap[0][27:16]), 28'h1D0);

    // Decode table: load, execute, then observe the following cycle's flush
    foreach (vecs[k]) begin
      do_cycle(vecs[k].ir, 1'b0, $sformatf("v%0d_load", k));
      do_cycle(12'h000, vecs[k].skip, $sformatf("v%0d_exec", k));
      chk($sformatf("v%0d_q4_decode", k), snap[3],
          {vecs[k].ir, 2'd3, vecs[k].mux, vecs[k].op, vecs[k].w, vecs[k].ram, 1'b0,
           vecs[k].pcl, vecs[k].push, vecs[k].pop, 1'b0, 1'b0});
      do_cycle(12'h000, 1'b0, $sformatf("v%0d_next", k));
      chk($sformatf("v%0d_flush_next", k), 28'(snap[0][1]), 28'(vecs[k].fln));
      chk($sformatf("v%0d_next_no_writes", k), 28'(snap[3][7:2]), 28'h0);
    end

    // Random instruction streams (SLEEP excluded) against the model
    for (int n = 0; n < 300; n++) begin
      r = 12'($urandom);
      if (r == 12'h003) r = 12'h000;
      do_cycle(r, 1'($urandom), $sformatf("rnd%0d", n));
    end

    // SLEEP: halt after Q4, then 20 quiet cycles
    do_reset("t6");
    do_cycle(12'h003, 1'b0, "t6_c0");
    do_cycle(12'h000, 1'b0, "t6_sleep");
    for (int n = 0; n < 20; n++) begin
      r = 12'($urandom);
      do_cycle(r, 1'($urandom), $sformatf("t6_halt%0d", n));
    end
    chk("t6_halted", 28'(halted), 28'h1);

    // SLEEP landing in a GOTO flush slot is ignored
    do_reset("t6b");
    do_cycle(12'hA05, 1'b0, "t6b_c0");
    do_cycle(12'h003, 1'b0, "t6b_goto");
    do_cycle(12'h000, 1'b0, "t6b_flushslot");
    chk("t6b_sleep_in_flush_flag", 28'(snap[0][1]), 28'h1);
    do_cycle(12'h000, 1'b0, "t6b_after");
    chk("t6b_not_halted", 28'(snap[0][0]), 28'h0);
    chk("t6b_pcinc_runs", 28'(snap[0][5]), 28'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
